// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types for the EX-stage multiply issue controller.
//   REG_BUS       : datapath width
//   mul_op_e      : funct3[1:0] multiply op encodings
//   mulc_state_e  : controller FSM states
//   mul_op_signed : op -> {rs1_signed, rs2_signed}
package mul_issue_ctrl_pkg;

  localparam int unsigned REG_BUS = 64;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [2:0] {
    MULC_ST_IDLE  = 3'd0,
    MULC_ST_ISSUE = 3'd1,
    MULC_ST_WAIT  = 3'd2,
    MULC_ST_DONE  = 3'd3,
    MULC_ST_DRAIN = 3'd4
  } mulc_state_e;

  function automatic logic [1:0] mul_op_signed(input mul_op_e op);
    case (op)
      MUL_OP_MULHSU: mul_op_signed = 2'b10;
      MUL_OP_MULHU:  mul_op_signed = 2'b00;
      default:       mul_op_signed = 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/mul_issue_ctrl_result_fmt.sv
// mul_result_fmt: selects and sign-extends the 64-bit writeback value
// from the full 2*XLEN product.
//   op_i   : multiply op (MUL takes the low half, MULH* the high half)
//   word_i : MULW, sign-extended low 32 bits
//   prod_i : full product
//   data_o : formatted result
module mul_result_fmt
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = REG_BUS
) (
  input  mul_op_e           op_i,
  input  logic              word_i,
  input  logic [2*XLEN-1:0] prod_i,
  output logic [XLEN-1:0]   data_o
);

  always_comb begin
    data_o = '0;
    if (word_i)
      data_o = {{(XLEN-32){prod_i[31]}}, prod_i[31:0]};
    else if (op_i == MUL_OP_MUL)
      data_o = prod_i[XLEN-1:0];
    else
      data_o = prod_i[2*XLEN-1:XLEN];
  end

endmodule

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: EX-stage controller in front of the booth2 multiplier.
// Decodes MUL/MULH/MULHSU/MULHU/MULW, latches operands and signedness,
// pulses mul_sel, stalls EX until the product returns and formats it.
// A one-entry product cache lets MUL after MULH* on the same operands
// complete without re-multiplying.
//   clk, rst                 : clock, synchronous active-high reset
//   mul_req/op/word          : request from EX
//   rs1_data, rs2_data       : operands
//   flush                    : kill of the EX instruction
//   mul_sel, mul_rs*_signed,
//   mul_rs1, mul_rs2         : multiplier start strobe and operands
//   mul_valid, mul_prod      : multiplier completion and product
//   ex_stall                 : pipeline stall
//   res_valid, res_data      : writeback result
module mul_issue_ctrl
  import mul_issue_ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = REG_BUS,
  parameter bit          CACHE_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mul_req,
  input  logic [1:0]        mul_op,
  input  logic              mul_word,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              flush,
  output logic              mul_sel,
  output logic              mul_rs1_signed,
  output logic              mul_rs2_signed,
  output logic [XLEN-1:0]   mul_rs1,
  output logic [XLEN-1:0]   mul_rs2,
  input  logic              mul_valid,
  input  logic [2*XLEN-1:0] mul_prod,
  output logic              ex_stall,
  output logic              res_valid,
  output logic [XLEN-1:0]   res_data
);

  mulc_state_e       state_q;
  mul_op_e           op_q;
  logic              word_q;
  logic              mul_sel_q;
  logic [XLEN-1:0]   rs1_q, rs2_q;
  logic              s1_q, s2_q;
  // Product register doubles as the cache data entry.
  logic [2*XLEN-1:0] prod_q;
  logic              cache_vld_q;
  logic [XLEN-1:0]   tag_rs1_q, tag_rs2_q;
  logic              tag_s1_q, tag_s2_q;

  mul_op_e           req_op;
  logic [XLEN-1:0]   rs1_d, rs2_d;
  logic              s1_d, s2_d;
  logic              accept, cache_hit;

  always_comb begin
    req_op     = mul_op_e'(mul_op);
    rs1_d      = mul_word ? {{(XLEN-32){rs1_data[31]}}, rs1_data[31:0]} : rs1_data;
    rs2_d      = mul_word ? {{(XLEN-32){rs2_data[31]}}, rs2_data[31:0]} : rs2_data;
    {s1_d, s2_d} = mul_op_signed(req_op);
    accept     = (state_q == MULC_ST_IDLE) && mul_req && !flush;
    // Low half of the product is signedness-independent, so MUL only
    // needs operand equality; MULW never hits.
    cache_hit  = CACHE_EN && cache_vld_q && !mul_word &&
                 (rs1_d == tag_rs1_q) && (rs2_d == tag_rs2_q) &&
                 ((req_op == MUL_OP_MUL) || ((s1_d == tag_s1_q) && (s2_d == tag_s2_q)));
  end

  always_comb begin
    ex_stall = 1'b0;
    if (!rst) begin
      case (state_q)
        MULC_ST_IDLE:                ex_stall = mul_req && !flush;
        MULC_ST_ISSUE, MULC_ST_WAIT: ex_stall = !flush;
        MULC_ST_DRAIN:               ex_stall = mul_req;
        default:                     ex_stall = 1'b0;
      endcase
    end
  end

  assign res_valid      = !rst && (state_q == MULC_ST_DONE) && !flush;
  assign mul_sel        = mul_sel_q;
  assign mul_rs1        = rs1_q;
  assign mul_rs2        = rs2_q;
  assign mul_rs1_signed = s1_q;
  assign mul_rs2_signed = s2_q;

  mul_result_fmt #(.XLEN(XLEN)) u_fmt (
    .op_i   (op_q),
    .word_i (word_q),
    .prod_i (prod_q),
    .data_o (res_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MULC_ST_IDLE;
      op_q        <= MUL_OP_MUL;
      word_q      <= 1'b0;
      mul_sel_q   <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prod_q      <= '0;
      cache_vld_q <= 1'b0;
      tag_rs1_q   <= '0;
      tag_rs2_q   <= '0;
      tag_s1_q    <= 1'b0;
      tag_s2_q    <= 1'b0;
    end else begin
      mul_sel_q <= 1'b0;
      // Completion fills the cache in WAIT and DRAIN alike, even when flushed.
      if ((state_q == MULC_ST_WAIT || state_q == MULC_ST_DRAIN) && mul_valid) begin
        prod_q      <= mul_prod;
        cache_vld_q <= 1'b1;
        tag_rs1_q   <= rs1_q;
        tag_rs2_q   <= rs2_q;
        tag_s1_q    <= s1_q;
        tag_s2_q    <= s2_q;
      end
      case (state_q)
        MULC_ST_IDLE: begin
          if (accept) begin
            op_q   <= req_op;
            word_q <= mul_word;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            if (cache_hit) begin
              state_q <= MULC_ST_DONE;
            end else begin
              state_q   <= MULC_ST_ISSUE;
              mul_sel_q <= 1'b1;
            end
          end
        end
        MULC_ST_ISSUE: state_q <= flush ? MULC_ST_DRAIN : MULC_ST_WAIT;
        MULC_ST_WAIT: begin
          if (mul_valid)  state_q <= flush ? MULC_ST_IDLE : MULC_ST_DONE;
          else if (flush) state_q <= MULC_ST_DRAIN;
        end
        MULC_ST_DONE:  state_q <= MULC_ST_IDLE;
        MULC_ST_DRAIN: if (mul_valid) state_q <= MULC_ST_IDLE;
        default:       state_q <= MULC_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         mul_req;
  logic [1:0]   mul_op;
  logic         mul_word;
  logic [63:0]  rs1_data, rs2_data;
  logic         flush;
  logic         mul_sel, mul_rs1_signed, mul_rs2_signed;
  logic [63:0]  mul_rs1, mul_rs2;
  logic         mul_valid;
  logic [127:0] mul_prod;
  logic         ex_stall, res_valid;
  logic [63:0]  res_data;

  int checks = 0;
  int errors = 0;
  int sel_cnt = 0;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  always @(posedge clk) if (mul_sel === 1'b1) sel_cnt <= sel_cnt + 1;

  mul_issue_ctrl #(.XLEN(64), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .mul_req(mul_req), .mul_op(mul_op), .mul_word(mul_word),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .mul_sel(mul_sel), .mul_rs1_signed(mul_rs1_signed), .mul_rs2_signed(mul_rs2_signed),
    .mul_rs1(mul_rs1), .mul_rs2(mul_rs2), .mul_valid(mul_valid), .mul_prod(mul_prod),
    .ex_stall(ex_stall), .res_valid(res_valid), .res_data(res_data)
  );

  task automatic set_req(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    mul_req = 1'b1; mul_op = op; mul_word = w; rs1_data = a; rs2_data = b;
  endtask

  task automatic clr_req();
    mul_req = 1'b0; mul_op = 2'b00; mul_word = 1'b0; rs1_data = '0; rs2_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; mul_valid = 1'b0; mul_prod = '0; clr_req();
    repeat (3) @(negedge clk);
    #1;
    checks++; if ({mul_sel, mul_rs1_signed, mul_rs2_signed, ex_stall, res_valid} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b exp 00000", {mul_sel, mul_rs1_signed, mul_rs2_signed, ex_stall, res_valid}); end
    checks++; if ({mul_rs1, mul_rs2, res_data} !== 192'b0) begin errors++; $display("FAIL reset_data got %h %h %h exp 0", mul_rs1, mul_rs2, res_data); end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if ({mul_sel, ex_stall, res_valid} !== 3'b0) begin errors++; $display("FAIL reset_release got %b exp 000", {mul_sel, ex_stall, res_valid}); end
  endtask

  task automatic test_mul_basic();
    int sel0;
    @(negedge clk); set_req(2'b00, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB); sel0 = sel_cnt; #1;
    checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL t1_stall_idle got %b exp 1", ex_stall); end
    @(negedge clk); #1;
    checks++; if (mul_sel !== 1'b1) begin errors++; $display("FAIL t1_sel got %b exp 1", mul_sel); end
    checks++; if ({mul_rs1_signed, mul_rs2_signed} !== 2'b11) begin errors++; $display("FAIL t1_signed got %b exp 11", {mul_rs1_signed, mul_rs2_signed}); end
    checks++; if ({mul_rs1, mul_rs2} !== {64'd3, 64'hFFFF_FFFF_FFFF_FFFB}) begin errors++; $display("FAIL t1_operands got %h %h exp 3 fffffffffffffffb", mul_rs1, mul_rs2); end
    @(negedge clk); mul_valid = 1'b1; mul_prod = {ONES, 64'hFFFF_FFFF_FFFF_FFF1}; #1;
    checks++; if ({mul_sel, ex_stall} !== 2'b01) begin errors++; $display("FAIL t1_wait got sel/stall %b exp 01", {mul_sel, ex_stall}); end
    @(negedge clk); mul_valid = 1'b0; clr_req(); #1;
    checks++; if ({res_valid, ex_stall} !== 2'b10) begin errors++; $display("FAIL t1_done got valid/stall %b exp 10", {res_valid, ex_stall}); end
    checks++; if (res_data !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL t1_data got %h exp fffffffffffffff1", res_data); end
    @(negedge clk); #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_pulse got %b exp 0", res_valid); end
    checks++; if (sel_cnt !== sel0 + 1) begin errors++; $display("FAIL t1_sel_count got %0d exp %0d", sel_cnt, sel0 + 1); end
  endtask

  task automatic test_cache_hit();
    int sel0;
    @(negedge clk); set_req(2'b11, 1'b0, ONES, ONES); #1;
    @(negedge clk); #1;
    checks++; if ({mul_sel, mul_rs1_signed, mul_rs2_signed} !== 3'b100) begin errors++; $display("FAIL t2_mulhu_issue got %b exp 100", {mul_sel, mul_rs1_signed, mul_rs2_signed}); end
    @(negedge clk); mul_valid = 1'b1; mul_prod = {64'hFFFF_FFFF_FFFF_FFFE, 64'h1};
    @(negedge clk); mul_valid = 1'b0; clr_req(); #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL t2_mulhu got %b %h exp 1 fffffffffffffffe", res_valid, res_data); end
    @(negedge clk); set_req(2'b00, 1'b0, ONES, ONES); sel0 = sel_cnt; #1;
    checks++; if (ex_stall !== 1'b1) begin errors++; $display("FAIL t2_hit_stall got %b exp 1", ex_stall); end
    @(negedge clk); clr_req(); #1;
    checks++; if (res_valid !== 1'b1 || mul_sel !== 1'b0) begin errors++; $display("FAIL t2_hit_latency got valid %b sel %b exp 1 0", res_valid, mul_sel); end
    checks++; if (res_data !== 64'h1) begin errors++; $display("FAIL t2_hit_data got %h exp 1", res_data); end
    @(negedge clk); #1;
    checks++; if (sel_cnt !== sel0) begin errors++; $display("FAIL t2_hit_no_sel got %0d exp %0d", sel_cnt, sel0); end
  endtask

  task automatic test_mulw_mulhsu();
    @(negedge clk); set_req(2'b00, 1'b1, 64'h1_0000_0002, 64'h4000_0000);
    @(negedge clk); #1;
    checks++; if ({mul_rs1, mul_rs2} !== {64'h2, 64'h4000_0000}) begin errors++; $display("FAIL t3_mulw_sext got %h %h exp 2 40000000", mul_rs1, mul_rs2); end
    @(negedge clk); mul_valid = 1'b1; mul_prod = 128'h8000_0000;
    @(negedge clk); mul_valid = 1'b0; clr_req(); #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_8000_0000) begin errors++; $display("FAIL t3_mulw got %b %h exp 1 ffffffff80000000", res_valid, res_data); end
    @(negedge clk); set_req(2'b10, 1'b0, ONES, 64'd2);
    @(negedge clk); #1;
    checks++; if ({mul_sel, mul_rs1_signed, mul_rs2_signed} !== 3'b110) begin errors++; $display("FAIL t3_mulhsu_issue got %b exp 110", {mul_sel, mul_rs1_signed, mul_rs2_signed}); end
    @(negedge clk); mul_valid = 1'b1; mul_prod = {ONES, 64'hFFFF_FFFF_FFFF_FFFE};
    @(negedge clk); mul_valid = 1'b0; clr_req(); #1;
    checks++; if (res_valid !== 1'b1 || res_data !== ONES) begin errors++; $display("FAIL t3_mulhsu got %b %h exp 1 ffffffffffffffff", res_valid, res_data); end
    @(negedge clk);
  endtask

  task automatic test_flush_drain();
    @(negedge clk); set_req(2'b00, 1'b0, 64'd7, 64'd9);
    @(negedge clk);
    @(negedge clk); flush = 1'b1; #1;
    checks++; if ({ex_stall, res_valid} !== 2'b00) begin errors++; $display("FAIL t4_flush_wait got %b exp 00", {ex_stall, res_valid}); end
    @(negedge clk); flush = 1'b0; set_req(2'b00, 1'b0, 64'd10, 64'd11); #1;
    checks++; if ({ex_stall, res_valid, mul_sel} !== 3'b100) begin errors++; $display("FAIL t4_drain_stall got %b exp 100", {ex_stall, res_valid, mul_sel}); end
    checks++; if (mul_rs1 !== 64'd7) begin errors++; $display("FAIL t4_drain_hold got %h exp 7", mul_rs1); end
    @(negedge clk); mul_valid = 1'b1; mul_prod = 128'd63; #1;
    checks++; if ({ex_stall, res_valid} !== 2'b10) begin errors++; $display("FAIL t4_drain_valid got %b exp 10", {ex_stall, res_valid}); end
    @(negedge clk); mul_valid = 1'b0; #1;
    checks++; if ({ex_stall, res_valid, mul_sel} !== 3'b100) begin errors++; $display("FAIL t4_accept got %b exp 100", {ex_stall, res_valid, mul_sel}); end
    @(negedge clk); #1;
    checks++; if (mul_sel !== 1'b1 || mul_rs1 !== 64'd10) begin errors++; $display("FAIL t4_reissue got sel %b rs1 %h exp 1 a", mul_sel, mul_rs1); end
    @(negedge clk); mul_valid = 1'b1; mul_prod = 128'd110;
    @(negedge clk); mul_valid = 1'b0; clr_req(); #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 64'd110) begin errors++; $display("FAIL t4_result got %b %h exp 1 6e", res_valid, res_data); end
    @(negedge clk);
  endtask

  task automatic test_flush_with_valid();
    int sel0;
    @(negedge clk); set_req(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    @(negedge clk);
    @(negedge clk); mul_valid = 1'b1; flush = 1'b1; mul_prod = {ONES, 64'hFFFF_FFFF_FFFF_FFF1}; #1;
    checks++; if ({ex_stall, res_valid} !== 2'b00) begin errors++; $display("FAIL t5_flush_valid got %b exp 00", {ex_stall, res_valid}); end
    @(negedge clk); mul_valid = 1'b0; flush = 1'b0; clr_req(); #1;
    checks++; if ({res_valid, ex_stall} !== 2'b00) begin errors++; $display("FAIL t5_no_result got %b exp 00", {res_valid, ex_stall}); end
    @(negedge clk); set_req(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5); sel0 = sel_cnt;
    @(negedge clk); clr_req(); #1;
    checks++; if (res_valid !== 1'b1 || res_data !== ONES) begin errors++; $display("FAIL t5_hit got %b %h exp 1 ffffffffffffffff", res_valid, res_data); end
    @(negedge clk); #1;
    checks++; if (sel_cnt !== sel0) begin errors++; $display("FAIL t5_hit_no_sel got %0d exp %0d", sel_cnt, sel0); end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk); set_req(2'b00, 1'b0, 64'd4, 64'd6);
    @(negedge clk);
    @(negedge clk); rst = 1'b1; clr_req();
    @(negedge clk); rst = 1'b0; mul_valid = 1'b1; mul_prod = 128'd24; #1;
    checks++; if ({ex_stall, res_valid, mul_sel} !== 3'b000) begin errors++; $display("FAIL t6_after_rst got %b exp 000", {ex_stall, res_valid, mul_sel}); end
    @(negedge clk); mul_valid = 1'b0; #1;
    checks++; if ({ex_stall, res_valid} !== 2'b00) begin errors++; $display("FAIL t6_stray_valid got %b exp 00", {ex_stall, res_valid}); end
    // These operands were cached before reset; MUL would hit if the entry survived.
    @(negedge clk); set_req(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    @(negedge clk); #1;
    checks++; if ({mul_sel, res_valid} !== 2'b10) begin errors++; $display("FAIL t6_miss got sel/valid %b exp 10", {mul_sel, res_valid}); end
    @(negedge clk); mul_valid = 1'b1; mul_prod = {ONES, 64'hFFFF_FFFF_FFFF_FFF1};
    @(negedge clk); mul_valid = 1'b0; clr_req(); #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++; $display("FAIL t6_result got %b %h exp 1 fffffffffffffff1", res_valid, res_data); end
    @(negedge clk);
  endtask

  task automatic test_flush_idle_done();
    @(negedge clk); set_req(2'b00, 1'b0, 64'd1, 64'd1); flush = 1'b1; #1;
    checks++; if (ex_stall !== 1'b0) begin errors++; $display("FAIL t7_flush_idle_stall got %b exp 0", ex_stall); end
    @(negedge clk); flush = 1'b0; clr_req(); #1;
    checks++; if ({mul_sel, ex_stall, res_valid} !== 3'b000) begin errors++; $display("FAIL t7_flush_idle_ignored got %b exp 000", {mul_sel, ex_stall, res_valid}); end
    @(negedge clk); set_req(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5);
    @(negedge clk); clr_req(); flush = 1'b1; #1;
    checks++; if ({res_valid, ex_stall} !== 2'b00) begin errors++; $display("FAIL t7_flush_done got %b exp 00", {res_valid, ex_stall}); end
    @(negedge clk); flush = 1'b0; #1;
    checks++; if ({res_valid, ex_stall, mul_sel} !== 3'b000) begin errors++; $display("FAIL t7_after_done got %b exp 000", {res_valid, ex_stall, mul_sel}); end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_cache_hit();
    test_mulw_mulhsu();
    test_flush_drain();
    test_flush_with_valid();
    test_reset_mid_op();
    test_flush_idle_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
